// File: rtl/conversion_bcd_binaire.sv
// Purpose: converts three captured BCD digits (hundreds, tens, units) into a
//          non-negative binary value 0..999 using shift-and-add times ten.
// Ports:
//   count    - clock, rising edge active
//   reset    - asynchronous active-high reset
//   start    - conversion request, sampled only when idle
//   centaine - BCD hundreds digit
//   dizaine  - BCD tens digit
//   unite    - BCD units digit
//   valeur   - registered converted value, held until the next successful conversion
//   done     - one-cycle pulse at the end of each accepted request
//   busy     - high while a conversion is in progress
//   erreur   - registered flag, last request held a digit greater than 9
module conversion_bcd_binaire #(
  parameter int unsigned WIDTH = 12
) (
  input  logic                    count,
  input  logic                    reset,
  input  logic                    start,
  input  logic [3:0]              centaine,
  input  logic [3:0]              dizaine,
  input  logic [3:0]              unite,
  output logic signed [WIDTH-1:0] valeur,
  output logic                    done,
  output logic                    busy,
  output logic                    erreur
);

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    CENT  = 3'd2,
    DIZ   = 3'd3,
    UNIT  = 3'd4
  } state_t;

  state_t               state_q,  state_d;
  logic [DIGIT_W-1:0]   cent_q,   cent_d;
  logic [DIGIT_W-1:0]   diz_q,    diz_d;
  logic [DIGIT_W-1:0]   unit_q,   unit_d;
  logic [WIDTH-1:0]     acc_q,    acc_d;
  logic [WIDTH-1:0]     valeur_q, valeur_d;
  logic                 done_q,   done_d;
  logic                 busy_q,   busy_d;
  logic                 erreur_q, erreur_d;

  // Multiply by ten as 8a + 2a, kept in WIDTH bits.
  function automatic logic [WIDTH-1:0] times_ten(input logic [WIDTH-1:0] a);
    return (a << 3) + (a << 1);
  endfunction

  // Next-state and datapath.
  always_comb begin
    state_d  = state_q;
    cent_d   = cent_q;
    diz_d    = diz_q;
    unit_d   = unit_q;
    acc_d    = acc_q;
    valeur_d = valeur_q;
    erreur_d = erreur_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cent_d   = centaine;
          diz_d    = dizaine;
          unit_d   = unite;
          erreur_d = 1'b0;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if ((cent_q > 4'd9) || (diz_q > 4'd9) || (unit_q > 4'd9)) begin
          erreur_d = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d  = CENT;
        end
      end
      CENT: begin
        acc_d   = WIDTH'(cent_q);
        state_d = DIZ;
      end
      DIZ: begin
        acc_d   = times_ten(acc_q) + WIDTH'(diz_q);
        state_d = UNIT;
      end
      UNIT: begin
        valeur_d = times_ten(acc_q) + WIDTH'(unit_q);
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered busy tracks the state register exactly.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge count or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cent_q   <= '0;
      diz_q    <= '0;
      unit_q   <= '0;
      acc_q    <= '0;
      valeur_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      erreur_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cent_q   <= cent_d;
      diz_q    <= diz_d;
      unit_q   <= unit_d;
      acc_q    <= acc_d;
      valeur_q <= valeur_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      erreur_q <= erreur_d;
    end
  end

  assign valeur = $signed(valeur_q);
  assign done   = done_q;
  assign busy   = busy_q;
  assign erreur = erreur_q;

endmodule

// File: tb/tb_conversion_bcd_binaire.sv
module tb_conversion_bcd_binaire;

  localparam int unsigned WIDTH = 12;

  logic                    count;
  logic                    reset;
  logic                    start;
  logic [3:0]              centaine;
  logic [3:0]              dizaine;
  logic [3:0]              unite;
  logic signed [WIDTH-1:0] valeur;
  logic                    done;
  logic                    busy;
  logic                    erreur;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  conversion_bcd_binaire #(.WIDTH(WIDTH)) dut (
    .count    (count),
    .reset    (reset),
    .start    (start),
    .centaine (centaine),
    .dizaine  (dizaine),
    .unite    (unite),
    .valeur   (valeur),
    .done     (done),
    .busy     (busy),
    .erreur   (erreur)
  );

  initial count = 1'b0;
  always #5 count = ~count;

  // Counts done pulses, sampled mid-cycle.
  always @(negedge count) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge count);
    #1;
  endtask

  // One request; success expects valeur=exp_val, rejection keeps prev_val.
  task automatic convert(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u,
                         input bit bad, input int exp_val, input string tag);
    int d0;
    centaine = c; dizaine = d; unite = u; start = 1'b1;
    step();                                   // edge k
    start = 1'b0;
    d0 = done_cnt;
    chk({tag, ".busy_k"}, int'(busy), 1);
    chk({tag, ".err_clr"}, int'(erreur), 0);
    if (bad) begin
      step();                                 // edge k+1
      chk({tag, ".done"}, int'(done), 1);
      chk({tag, ".erreur"}, int'(erreur), 1);
      chk({tag, ".busy_end"}, int'(busy), 0);
      chk({tag, ".valeur_kept"}, int'(valeur), exp_val);
    end else begin
      for (int i = 1; i <= 3; i++) begin
        step();
        chk({tag, ".busy_mid"}, int'(busy), 1);
        chk({tag, ".done_mid"}, int'(done), 0);
      end
      step();                                 // edge k+4
      chk({tag, ".done"}, int'(done), 1);
      chk({tag, ".busy_end"}, int'(busy), 0);
      chk({tag, ".valeur"}, int'(valeur), exp_val);
      chk({tag, ".erreur"}, int'(erreur), 0);
    end
    step();
    chk({tag, ".done_low"}, int'(done), 0);
    chk({tag, ".pulses"}, done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; centaine = '0; dizaine = '0; unite = '0;
    step(); step();
    chk("rst.valeur", int'(valeur), 0);
    chk("rst.done",   int'(done),   0);
    chk("rst.busy",   int'(busy),   0);
    chk("rst.erreur", int'(erreur), 0);
    reset = 1'b0;
    step();

    convert(4'd1, 4'd2, 4'd3, 1'b0, 123, "c123");
    convert(4'd9, 4'd9, 4'd9, 1'b0, 999, "c999");
    convert(4'd0, 4'd0, 4'd0, 1'b0, 0,   "c000");
    convert(4'd1, 4'd2, 4'd3, 1'b0, 123, "c123b");
    convert(4'd4, 4'd10, 4'd5, 1'b1, 123, "rej");
    convert(4'd15, 4'd0, 4'd0, 1'b1, 123, "rej_c");
    convert(4'd0, 4'd0, 4'd12, 1'b1, 123, "rej_u");
    convert(4'd8, 4'd0, 4'd1, 1'b0, 801, "c801");

    // Digit changes and start re-pulse during the conversion are ignored.
    d0 = done_cnt;
    centaine = 4'd4; dizaine = 4'd5; unite = 4'd6; start = 1'b1;
    step();                                   // edge k
    start = 1'b0;
    centaine = 4'd7; dizaine = 4'd7; unite = 4'd7;
    step(); step();                           // now in DIZ
    start = 1'b1;
    step();
    start = 1'b0;
    step();                                   // edge k+4
    chk("ign.done", int'(done), 1);
    chk("ign.valeur", int'(valeur), 456);
    step(); step(); step();
    chk("ign.busy", int'(busy), 0);
    chk("ign.pulses", done_cnt - d0, 1);

    // Reset asserted mid-cycle while in DIZ aborts without a done pulse.
    d0 = done_cnt;
    centaine = 4'd5; dizaine = 4'd5; unite = 4'd5; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();                           // in DIZ
    #2;
    reset = 1'b1;
    #1;
    chk("arst.valeur", int'(valeur), 0);
    chk("arst.busy",   int'(busy),   0);
    chk("arst.done",   int'(done),   0);
    chk("arst.erreur", int'(erreur), 0);
    step();
    reset = 1'b0;
    step(); step(); step();
    chk("arst.pulses", done_cnt - d0, 0);
    chk("arst.idle", int'(busy), 0);
    convert(4'd0, 4'd4, 4'd2, 1'b0, 42, "c042");

    // start held high: a conversion every 5 cycles.
    d0 = done_cnt;
    centaine = 4'd3; dizaine = 4'd0; unite = 4'd7; start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i <= 4; i++) begin
        step();
        chk("hold.done_mid", int'(done), 0);
        chk("hold.busy_mid", int'(busy), 1);
      end
      step();
      chk("hold.done", int'(done), 1);
      chk("hold.valeur", int'(valeur), 307);
    end
    start = 1'b0;
    step();
    chk("hold.busy_end", int'(busy), 0);
    chk("hold.pulses", done_cnt - d0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
